// File: rtl/i2c_master_fifo_top.sv
// ---------------------------------------------------------------------------
// i2c_master_fifo_top
//
// WISHBONE revB.2 slave front-end for the I2C byte controller. Software queues
// whole transactions (START / address / data / STOP) into a command FIFO; a
// two-state sequencer feeds them to i2c_master_byte_ctrl back-to-back and
// collects received bytes in an RX FIFO.
//
// Optional build macro: I2C_FIFO_STATS_EN adds a completed-byte counter at
// address 7. Without it, address 7 reads 0x00 and writes are ignored.
//
// Ports:
//   wb_clk_i, rst_i (async, high), wb_rst_i (sync, high)
//   wb_adr_i/wb_dat_i/wb_dat_o/wb_we_i/wb_stb_i/wb_cyc_i/wb_ack_o : WB slave
//   wb_inta_o          : registered irq_flag & CTR.IEN
//   bc_ena, bc_clk_cnt : enable and prescale to the byte controller
//   bc_start/stop/read/write/ack_in, bc_din : registered command to byte ctrl
//   bc_cmd_ack, bc_ack_out, bc_dout, bc_busy, bc_al : byte controller status
//   tip_o              : transfer in progress
//
// Handshakes: a WB access is a request while cyc&stb is high; ack rises one
// edge later and drops the edge after, so every access is two cycles. Writes
// commit on the edge where ack is already high; read data is loaded on the
// edge that raises ack. Towards the byte controller the command bits act as
// "valid" and are held steady until bc_cmd_ack (the "ready"/done pulse) is
// seen, after which they drop to zero for at least one cycle.
// ---------------------------------------------------------------------------
module i2c_master_fifo_top #(
   parameter int          FIFO_AW    = 4,
   parameter logic [15:0] PRER_RST   = 16'hFFFF,
   parameter logic [7:0]  CTR_RST    = 8'h00,
   parameter int          RX_IRQ_LVL = 1
) (
   input  logic        wb_clk_i,
   input  logic        rst_i,
   input  logic        wb_rst_i,
   input  logic [2:0]  wb_adr_i,
   input  logic [7:0]  wb_dat_i,
   output logic [7:0]  wb_dat_o,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic        wb_inta_o,
   output logic        bc_ena,
   output logic [15:0] bc_clk_cnt,
   output logic        bc_start,
   output logic        bc_stop,
   output logic        bc_read,
   output logic        bc_write,
   output logic        bc_ack_in,
   output logic [7:0]  bc_din,
   input  logic        bc_cmd_ack,
   input  logic        bc_ack_out,
   input  logic [7:0]  bc_dout,
   input  logic        bc_busy,
   input  logic        bc_al,
   output logic        tip_o
);
   localparam int                DEPTH    = 1 << FIFO_AW;
   localparam int                LW       = FIFO_AW + 1;
   localparam logic [FIFO_AW:0]  LVL_FULL = LW'(DEPTH);
   localparam logic [FIFO_AW:0]  IRQ_LVL  = LW'(RX_IRQ_LVL);

   typedef enum logic [0:0] {S_IDLE, S_ISSUE} seq_state_t;

   // ---------------- registers ----------------
   logic              r_ack;
   logic [7:0]        r_dat_o;
   logic [15:0]       r_prer;
   logic [7:0]        r_ctr;
   logic [4:0]        r_stage;       // {sta, sto, rd, wr, ack}
   seq_state_t        r_state;
   logic [12:0]       r_bc_cmd;      // {start, stop, read, write, ack_in, din}
   logic [12:0]       r_cmd_mem [DEPTH];
   logic [FIFO_AW-1:0] r_cmd_wp, r_cmd_rp;
   logic [FIFO_AW:0]  r_cmd_lvl;
   logic [7:0]        r_rx_mem [DEPTH];
   logic [FIFO_AW-1:0] r_rx_wp, r_rx_rp;
   logic [FIFO_AW:0]  r_rx_lvl;
   logic              r_ovf, r_al, r_rxack, r_irq_flag, r_inta;

   // ---------------- bus decode ----------------
   logic        w_acc_start, w_wr, w_rd_start;
   logic        w_flush, w_push_req, w_iack, w_rx_pop;
   logic        w_cmd_empty, w_cmd_full, w_rx_empty, w_rx_full;
   logic        w_cmd_push, w_rx_push, w_ovf_set, w_irq_set, w_can_issue;
   logic        w_issue, w_done;
   seq_state_t  w_state_nxt;
   logic [12:0] w_head;
   logic [7:0]  w_sr, w_rd_data, w_stat;

   assign w_acc_start = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr        = wb_cyc_i & wb_stb_i & r_ack & wb_we_i;
   assign w_rd_start  = w_acc_start & ~wb_we_i;
   assign w_flush     = w_wr & (wb_adr_i == 3'd2) & wb_dat_i[0];
   assign w_push_req  = w_wr & (wb_adr_i == 3'd3);
   assign w_iack      = w_wr & (wb_adr_i == 3'd4) & wb_dat_i[0];

   assign w_cmd_empty = (r_cmd_lvl == '0);
   assign w_cmd_full  = (r_cmd_lvl == LVL_FULL);
   assign w_rx_empty  = (r_rx_lvl == '0);
   assign w_rx_full   = (r_rx_lvl == LVL_FULL);
   assign w_head      = r_cmd_mem[r_cmd_rp];

   // The RX pop happens on the same edge that captures the read data.
   assign w_rx_pop    = w_rd_start & (wb_adr_i == 3'd3) & ~w_rx_empty;

   // A read entry only issues when its byte is guaranteed a slot in the RX FIFO.
   assign w_can_issue = r_ctr[7] & ~w_cmd_empty & (~w_head[10] | ~w_rx_full)
                        & ~bc_al & ~w_flush;

   // ---------------- sequencer ----------------
   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i)         r_state <= S_IDLE;
      else if (wb_rst_i) r_state <= S_IDLE;
      else               r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_can_issue) begin
               w_issue     = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bc_cmd_ack) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // Arbitration loss aborts whatever is in flight; it is not a completion.
      if (bc_al) begin
         w_done      = 1'b0;
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i)                r_bc_cmd <= '0;
      else if (wb_rst_i)        r_bc_cmd <= '0;
      else if (bc_al | w_done)  r_bc_cmd <= '0;
      else if (w_issue)         r_bc_cmd <= w_head;
   end

   // ---------------- command FIFO ----------------
   assign w_cmd_push = w_push_req & (~w_cmd_full | w_issue) & ~bc_al;
   assign w_ovf_set  = w_push_req & w_cmd_full & ~w_issue;

   always_ff @(posedge wb_clk_i) begin
      if (w_cmd_push) r_cmd_mem[r_cmd_wp] <= {r_stage, wb_dat_i};
      if (w_rx_push)  r_rx_mem[r_rx_wp]   <= bc_dout;
   end

   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i | wb_rst_i) begin
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_cmd_lvl <= '0;
      end else if (w_flush | bc_al) begin
         r_cmd_wp  <= '0;
         r_cmd_rp  <= '0;
         r_cmd_lvl <= '0;
      end else begin
         if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 1'b1;
         if (w_issue)    r_cmd_rp <= r_cmd_rp + 1'b1;
         r_cmd_lvl <= r_cmd_lvl + LW'(w_cmd_push) - LW'(w_issue);
      end
   end

   // ---------------- RX FIFO ----------------
   // r_bc_cmd[10] is still the in-flight rd bit on the completing edge.
   assign w_rx_push = w_done & r_bc_cmd[10] & ~w_flush & (~w_rx_full | w_rx_pop);

   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i | wb_rst_i) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_lvl <= '0;
      end else if (w_flush) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_lvl <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         r_rx_lvl <= r_rx_lvl + LW'(w_rx_push) - LW'(w_rx_pop);
      end
   end

   // ---------------- status and interrupt ----------------
   assign w_irq_set = ((r_state == S_ISSUE) & bc_cmd_ack & w_cmd_empty) | bc_al
                      | (r_rx_lvl >= IRQ_LVL);

   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i | wb_rst_i) begin
         r_ovf      <= 1'b0;
         r_al       <= 1'b0;
         r_rxack    <= 1'b0;
         r_irq_flag <= 1'b0;
         r_inta     <= 1'b0;
      end else begin
         if (w_flush)        r_ovf <= 1'b0;
         else if (w_ovf_set) r_ovf <= 1'b1;
         if (bc_al)                          r_al <= 1'b1;
         else if (w_cmd_push & r_stage[4])   r_al <= 1'b0;
         if (w_done) r_rxack <= bc_ack_out;
         // A set in the same cycle as IACK wins.
         if (w_irq_set)   r_irq_flag <= 1'b1;
         else if (w_iack) r_irq_flag <= 1'b0;
         r_inta <= r_irq_flag & r_ctr[6];
      end
   end

   // ---------------- WISHBONE registers ----------------
   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i | wb_rst_i) begin
         r_ack   <= 1'b0;
         r_dat_o <= 8'h00;
         r_prer  <= PRER_RST;
         r_ctr   <= CTR_RST;
         r_stage <= '0;
      end else begin
         r_ack <= wb_cyc_i & wb_stb_i & ~r_ack;
         if (w_acc_start) r_dat_o <= w_rd_data;
         if (w_wr) begin
            case (wb_adr_i)
               3'd0:    r_prer[7:0]  <= wb_dat_i;
               3'd1:    r_prer[15:8] <= wb_dat_i;
               3'd2:    r_ctr        <= {wb_dat_i[7:1], 1'b0};  // FLUSH self-clears
               3'd4:    r_stage      <= wb_dat_i[7:3];
               default: ;
            endcase
         end
      end
   end

`ifdef I2C_FIFO_STATS_EN
   logic [7:0] r_stat_cnt;
   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i | wb_rst_i)               r_stat_cnt <= 8'h00;
      else if (w_wr & (wb_adr_i == 3'd7)) r_stat_cnt <= 8'h00;
      else if (w_done)                    r_stat_cnt <= r_stat_cnt + 8'h01;
   end
   assign w_stat = r_stat_cnt;
`else
   assign w_stat = 8'h00;
`endif

   assign w_sr = {r_rxack, bc_busy, r_al, r_ovf, w_cmd_full, ~w_rx_empty, tip_o,
                  r_irq_flag};

   always_comb begin
      w_rd_data = 8'h00;
      case (wb_adr_i)
         3'd0:    w_rd_data = r_prer[7:0];
         3'd1:    w_rd_data = r_prer[15:8];
         3'd2:    w_rd_data = r_ctr;
         3'd3:    w_rd_data = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
         3'd4:    w_rd_data = w_sr;
         3'd5:    w_rd_data = 8'(r_cmd_lvl);
         3'd6:    w_rd_data = 8'(r_rx_lvl);
         3'd7:    w_rd_data = w_stat;
         default: w_rd_data = 8'h00;
      endcase
   end

   // ---------------- outputs ----------------
   assign wb_ack_o   = r_ack;
   assign wb_dat_o   = r_dat_o;
   assign wb_inta_o  = r_inta;
   assign bc_ena     = r_ctr[7];
   assign bc_clk_cnt = r_prer;
   assign bc_start   = r_bc_cmd[12];
   assign bc_stop    = r_bc_cmd[11];
   assign bc_read    = r_bc_cmd[10];
   assign bc_write   = r_bc_cmd[9];
   assign bc_ack_in  = r_bc_cmd[8];
   assign bc_din     = r_bc_cmd[7:0];
   assign tip_o      = (r_state == S_ISSUE) | ~w_cmd_empty;
endmodule

// File: tb/tb_i2c_master_fifo_top.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_fifo_top
//
// Directed bench for i2c_master_fifo_top (default parameters, FIFO depth 16).
// The model is transaction level: a queue of command entries the sequencer
// still owes the byte controller, a queue of bytes software should read back,
// and shadow copies of PRER/CTR/stage. A monitor compares every issued command
// and the held command outputs against that queue each cycle; a responder
// plays the byte controller (ack after 20 cycles).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_master_fifo_top;
   localparam int DEPTH = 16;
`ifdef I2C_FIFO_STATS_EN
   localparam logic [7:0] STAT_EXP = 8'h02;
`else
   localparam logic [7:0] STAT_EXP = 8'h00;
`endif

   // ---------------- clock / reset ----------------
   logic        wb_clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        wb_rst_i = 1'b0;
   logic [2:0]  wb_adr_i = '0;
   logic [7:0]  wb_dat_i = '0;
   logic [7:0]  wb_dat_o;
   logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
   logic        wb_ack_o, wb_inta_o, bc_ena;
   logic [15:0] bc_clk_cnt;
   logic        bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
   logic [7:0]  bc_din;
   logic        bc_cmd_ack = 1'b0, bc_ack_out = 1'b0, bc_busy = 1'b0, bc_al = 1'b0;
   logic [7:0]  bc_dout = '0;
   logic        tip_o;

   always #5 wb_clk_i = ~wb_clk_i;

   i2c_master_fifo_top dut (
      .wb_clk_i(wb_clk_i), .rst_i(rst_i), .wb_rst_i(wb_rst_i),
      .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
      .wb_ack_o(wb_ack_o), .wb_inta_o(wb_inta_o),
      .bc_ena(bc_ena), .bc_clk_cnt(bc_clk_cnt),
      .bc_start(bc_start), .bc_stop(bc_stop), .bc_read(bc_read),
      .bc_write(bc_write), .bc_ack_in(bc_ack_in), .bc_din(bc_din),
      .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout),
      .bc_busy(bc_busy), .bc_al(bc_al), .tip_o(tip_o)
   );

   // ---------------- model state / scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [12:0] exp_cmd_q[$];   // entries pushed but not yet issued
   logic [7:0]  exp_rx_q[$];    // bytes software should read back
   logic [7:0]  rd_data_q[$];   // bytes the responder will return
   logic [15:0] m_prer  = 16'hFFFF;
   logic [7:0]  m_ctr   = 8'h00;
   logic [7:0]  m_stage = 8'h00;
   int          issue_count = 0;
   int          gap_at [0:1023];
   logic [12:0] issued_log [0:1023];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s", name);
   endtask

   // Shadow registers follow a write once its ack is seen (it commits next edge).
   task automatic model_write(input logic [2:0] adr, input logic [7:0] dat);
      case (adr)
         3'd0: m_prer[7:0]  = dat;
         3'd1: m_prer[15:8] = dat;
         3'd2: begin
            m_ctr = {dat[7:1], 1'b0};
            if (dat[0]) begin
               exp_cmd_q.delete();
               exp_rx_q.delete();
            end
         end
         3'd3: if (exp_cmd_q.size() < DEPTH) exp_cmd_q.push_back({m_stage[7:3], dat});
         3'd4: m_stage = dat;
         default: ;
      endcase
   endtask

   // ---------------- driver tasks ----------------
   task automatic wb_access(input logic [2:0] adr, input logic we, input logic [7:0] dat,
                            output logic [7:0] rdat);
      int n;
      @(negedge wb_clk_i);
      wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      n = 0;
      rdat = 8'h00;
      do begin
         @(negedge wb_clk_i);
         n++;
      end while (!wb_ack_o && n < 8);
      if (!wb_ack_o) fail_now("wb_ack_timeout");
      else begin
         rdat = wb_dat_o;
         if (we) model_write(adr, dat);
      end
      @(negedge wb_clk_i);
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic wb_write(input logic [2:0] adr, input logic [7:0] dat);
      logic [7:0] d;
      wb_access(adr, 1'b1, dat, d);
   endtask

   task automatic check_rd(input string name, input logic [2:0] adr, input logic [7:0] exp);
      logic [7:0] d;
      wb_access(adr, 1'b0, 8'h00, d);
      check(name, d, exp);
   endtask

   // Pop address 3 and compare against the model's expected RX byte.
   task automatic check_rx_pop(input string name);
      logic [7:0] d, e;
      wb_access(3'd3, 1'b0, 8'h00, d);
      e = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 8'h00;
      check(name, d, e);
   endtask

   task automatic push_entry(input logic [7:0] stage, input logic [7:0] dat);
      wb_write(3'd4, stage);
      wb_write(3'd3, dat);
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      while (tip_o && n < bound) begin
         @(negedge wb_clk_i);
         n++;
      end
      if (tip_o) fail_now(name);
   endtask

   task automatic wait_issues(input int target, input int bound, input string name);
      int n = 0;
      while (issue_count < target && n < bound) begin
         @(negedge wb_clk_i);
         n++;
      end
      if (issue_count < target) fail_now(name);
   endtask

   // ---------------- byte controller responder ----------------
   initial begin : responder
      int cnt;
      cnt = 0;
      forever begin
         @(negedge wb_clk_i);
         if (bc_start | bc_stop | bc_read | bc_write) begin
            cnt++;
            if (cnt == 20) begin
               bc_cmd_ack = 1'b1;
               if (bc_read) begin
                  bc_dout = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 8'h00;
                  exp_rx_q.push_back(bc_dout);
               end
               @(negedge wb_clk_i);
               bc_cmd_ack = 1'b0;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // ---------------- compare process ----------------
   initial begin : monitor
      logic        prev_act, act;
      logic [12:0] cur, obs;
      int          idle;
      prev_act = 1'b0; cur = '0; idle = 0;
      forever begin
         @(posedge wb_clk_i);
         #3;
         check("bc_clk_cnt", bc_clk_cnt, m_prer);
         check("bc_ena", bc_ena, m_ctr[7]);
         act = bc_start | bc_stop | bc_read | bc_write;
         obs = {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din};
         if (act && !prev_act) begin
            if (exp_cmd_q.size() == 0) fail_now("unexpected_issue");
            else begin
               cur = exp_cmd_q.pop_front();
               check("issue_entry", obs, cur);
            end
            gap_at[issue_count]     = idle;
            issued_log[issue_count] = obs;
            issue_count++;
         end else if (act) begin
            check("cmd_hold", obs, cur);
         end else begin
            check("cmd_idle_zero", obs, 13'h0);
         end
         idle = act ? 0 : idle + 1;
         prev_act = act;
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin : stimulus
      int base;
      int guard;
      logic stop_loop;
      #1 rst_i = 1'b1;
      repeat (3) @(negedge wb_clk_i);
      rst_i = 1'b0;

      // Reset state
      check("rst_inta", wb_inta_o, 1'b0);
      check("rst_tip", tip_o, 1'b0);
      check_rd("rst_prer_hi", 3'd1, 8'hFF);
      check_rd("rst_prer_lo", 3'd0, 8'hFF);
      check_rd("rst_sr", 3'd4, 8'h00);
      check_rd("rst_ctr", 3'd2, 8'h00);
      check_rd("rst_cmd_lvl", 3'd5, 8'h00);
      check_rd("rst_rx_lvl", 3'd6, 8'h00);
      check_rd("rst_stat", 3'd7, 8'h00);

      // Prescale write/readback, then synchronous reset restores it
      wb_write(3'd0, 8'h34);
      wb_write(3'd1, 8'h12);
      check_rd("prer_lo", 3'd0, 8'h34);
      check_rd("prer_hi", 3'd1, 8'h12);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b1;
      m_prer = 16'hFFFF; m_ctr = 8'h00; m_stage = 8'h00;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      check_rd("srst_prer_lo", 3'd0, 8'hFF);

      // Write transaction: START+A0, 55, 12+STOP
      base = issue_count;
      push_entry(8'h90, 8'hA0);
      push_entry(8'h10, 8'h55);
      push_entry(8'h50, 8'h12);
      check_rd("wr_cmd_lvl", 3'd5, 8'h03);
      check_rd("wr_sr_queued", 3'd4, 8'h02);
      wb_write(3'd2, 8'hC0);
      wait_issues(base + 2, 200, "wr_issue2_timeout");
      check_rd("wr_sr_mid", 3'd4, 8'h02);
      check("wr_inta_mid", wb_inta_o, 1'b0);
      wait_idle(200, "wr_idle_timeout");
      check("wr_issue_cnt", issue_count - base, 3);
      check("wr_entry0", issued_log[base], 13'h12A0);
      check("wr_entry1", issued_log[base + 1], 13'h0255);
      check("wr_entry2", issued_log[base + 2], 13'h0A12);
      check("wr_gap1", gap_at[base + 1], 1);
      check("wr_gap2", gap_at[base + 2], 1);
      check_rd("wr_sr_done", 3'd4, 8'h01);
      check("wr_inta", wb_inta_o, 1'b1);
      wb_write(3'd4, 8'h01);
      check_rd("iack_sr", 3'd4, 8'h00);
      check("iack_inta", wb_inta_o, 1'b0);

      // Reads: fill the RX FIFO, then a further read entry must stall
      for (int i = 0; i < 16; i++) rd_data_q.push_back(8'(8'h40 + i));
      rd_data_q.push_back(8'h99);
      wb_write(3'd4, 8'h20);
      for (int i = 0; i < 16; i++) wb_write(3'd3, 8'h00);
      wait_idle(600, "rd_idle_timeout");
      check_rd("rd_rx_lvl_full", 3'd6, 8'h10);
      check_rd("rd_sr_full", 3'd4, 8'h05);
      wb_write(3'd3, 8'h00);
      repeat (30) @(negedge wb_clk_i);
      check("rd_stall_read", bc_read, 1'b0);
      check("rd_stall_tip", tip_o, 1'b1);
      check_rd("rd_stall_lvl", 3'd5, 8'h01);
      check("rd_first_exp", exp_rx_q[0], 8'h40);
      check_rx_pop("rd_pop_first");
      wait_idle(100, "rd_unstall_timeout");
      check_rd("rd_rx_lvl_again", 3'd6, 8'h10);
      check("rd_last_exp", exp_rx_q[15], 8'h99);
      for (int i = 0; i < 16; i++) check_rx_pop("rd_pop");
      check_rx_pop("rd_pop_empty");
      check_rd("rd_rx_lvl_empty", 3'd6, 8'h00);

      // Overflow with EN=0, then FLUSH
      wb_write(3'd2, 8'h00);
      wb_write(3'd4, 8'h01);
      wb_write(3'd4, 8'h10);
      for (int i = 0; i < 17; i++) wb_write(3'd3, 8'(i));
      bc_busy = 1'b1;
      check_rd("ovf_cmd_lvl", 3'd5, 8'h10);
      check("ovf_model_lvl", exp_cmd_q.size(), 16);
      check_rd("ovf_sr", 3'd4, 8'h5A);
      bc_busy = 1'b0;
      wb_write(3'd2, 8'h01);
      check_rd("flush_cmd_lvl", 3'd5, 8'h00);
      check_rd("flush_rx_lvl", 3'd6, 8'h00);
      check_rd("flush_sr", 3'd4, 8'h00);
      check_rd("flush_ctr", 3'd2, 8'h00);

      // Arbitration lost during the second of four entries
      base = issue_count;
      push_entry(8'h90, 8'h01);
      push_entry(8'h10, 8'h02);
      wb_write(3'd3, 8'h03);
      wb_write(3'd3, 8'h04);
      wb_write(3'd2, 8'hC0);
      wait_issues(base + 2, 200, "al_issue2_timeout");
      repeat (5) @(negedge wb_clk_i);
      bc_al = 1'b1;
      exp_cmd_q.delete();
      @(negedge wb_clk_i);
      bc_al = 1'b0;
      check("al_cmd_bits", {bc_start, bc_stop, bc_read, bc_write}, 4'h0);
      check("al_tip", tip_o, 1'b0);
      check_rd("al_cmd_lvl", 3'd5, 8'h00);
      check_rd("al_sr", 3'd4, 8'h21);
      check("al_inta", wb_inta_o, 1'b1);
      wb_write(3'd2, 8'h40);
      push_entry(8'h90, 8'h77);
      check_rd("al_clear_sr", 3'd4, 8'h03);

      // Received NACK shows up in SR[7]
      bc_ack_out = 1'b1;
      wb_write(3'd4, 8'h01);
      wb_write(3'd2, 8'hC0);
      wait_idle(100, "nack_idle_timeout");
      check_rd("nack_sr", 3'd4, 8'h81);
      bc_ack_out = 1'b0;

      // 258 completed bytes for the statistics counter
      wb_write(3'd4, 8'h11);
      wb_write(3'd7, 8'h00);
      stop_loop = 1'b0;
      for (int i = 0; i < 258 && !stop_loop; i++) begin
         guard = 0;
         while (exp_cmd_q.size() >= 8 && guard < 100) begin
            @(negedge wb_clk_i);
            guard++;
         end
         if (guard >= 100) begin
            fail_now("stats_push_stall");
            stop_loop = 1'b1;
         end else begin
            wb_write(3'd3, 8'(i));
         end
      end
      wait_idle(400, "stats_idle_timeout");
      check_rd("stats_count", 3'd7, STAT_EXP);
      wb_write(3'd7, 8'h55);
      check_rd("stats_cleared", 3'd7, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
